// File: rtl/uart_pkg.sv
// Shared types for the configurable UART transmitter.
// Holds the frame FSM state enum, parity mode constants and a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Parity bit that makes the total ones count odd or even.
    // Words are zero-extended to 9 bits, which does not change parity.
    function automatic logic parity_bit(parity_e mode, logic [8:0] data);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter.
// Ports: clk_i, rst_i, push_i/data_i in, pop_i, data_o (head word), count_o,
// full_o, empty_o. Pushes when full and pops when empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small input FIFO.
// Ports: clk_50, rst, baud_tick, tx_data/tx_valid/tx_ready (push side),
// tx_serial (line, idle high), tx_busy, fifo_count.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_50,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_serial,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam parity_e PMODE = parity_e'(2'(PARITY));
    localparam int MAXB = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CW   = $clog2(MAXB + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [CW-1:0]        cnt_q;
    logic                 serial_q;
    logic                 par_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 last_stop;
    logic                 pop;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_50),
        .rst_i   (rst),
        .push_i  (tx_valid),
        .pop_i   (pop),
        .data_i  (tx_data),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign tx_serial = serial_q;
    assign tx_busy   = (state_q != ST_IDLE);

    // A new frame begins from IDLE or straight out of the final stop bit.
    assign last_stop = (state_q == ST_STOP) && (cnt_q == LAST_STOP);
    assign pop = baud_tick && !fifo_empty &&
                 ((state_q == ST_IDLE) || last_stop);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b1;
            par_q    <= 1'b0;
        end else if (baud_tick) begin
            if (pop) begin
                state_q  <= ST_START;
                shift_q  <= fifo_head;
                par_q    <= parity_bit(PMODE, 9'(fifo_head));
                cnt_q    <= '0;
                serial_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        serial_q <= 1'b1;
                    end
                    ST_START: begin
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        cnt_q    <= '0;
                        state_q  <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (cnt_q == LAST_DATA) begin
                            cnt_q <= '0;
                            if (PMODE != PAR_NONE) begin
                                serial_q <= par_q;
                                state_q  <= ST_PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                state_q  <= ST_STOP;
                            end
                        end else begin
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                            cnt_q    <= cnt_q + CW'(1);
                        end
                    end
                    ST_PARITY: begin
                        serial_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        serial_q <= 1'b1;
                        if (last_stop) begin
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        serial_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
